// File: rtl/fuzz_vec_sequencer_if.sv
// fuzz_vec_sequencer_if: control, seed, response and result bundle
// shared by the sequencer (slave) and its driver/observer (master).
interface fuzz_vec_sequencer_if #(
  parameter int VEC_W = 49,
  parameter int Y_W   = 350,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [63:0]      seed;
  logic [Y_W-1:0]   y;
`ifdef FUZZ_SEQ_STALL_EN
  logic             stall;
`endif
  logic [VEC_W-1:0] vec_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] vec_cnt;
  logic [31:0]      signature;

  modport master (
`ifdef FUZZ_SEQ_STALL_EN
    output stall,
`endif
    output start, abort, seed, y,
    input  vec_out, busy, done, vec_cnt, signature
  );

  modport slave (
`ifdef FUZZ_SEQ_STALL_EN
    input  stall,
`endif
    input  start, abort, seed, y,
    output vec_out, busy, done, vec_cnt, signature
  );
endinterface

// File: rtl/fuzz_vec_sequencer.sv
// fuzz_vec_sequencer: LFSR vector generator + MISR response compactor.
// Optional hold input enabled by macro FUZZ_SEQ_STALL_EN.
module fuzz_vec_sequencer #(
  parameter int VEC_W   = 49,
  parameter int Y_W     = 350,
  parameter int NUM_VEC = 21,
  parameter int SETTLE  = 1,
  parameter int CNT_W   = 8
) (
  input logic                clk,
  input logic                rst_n,
  fuzz_vec_sequencer_if.slave bus
);

  localparam int NCH = (Y_W + 31) / 32;
  localparam int YE  = NCH * 32;
  localparam int SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SET_LAST =
    SW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CNT_W-1:0] NV = CNT_W'(NUM_VEC);
  localparam logic [63:0] MASK = 64'hD800000000000000;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [63:0]      lfsr_q, lfsr_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [31:0]      sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    set_q, set_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [63:0]      lfsr_adv;
  logic [YE-1:0]    y_ext;
  logic [31:0]      fold;
  logic [31:0]      misr;
  logic             hold;

  assign lfsr_adv = {1'b0, lfsr_q[63:1]}
                  ^ (lfsr_q[0] ? MASK : 64'h0);
  assign y_ext = YE'(bus.y);
  assign misr = {sig_q[30:0], 1'b0}
              ^ (sig_q[31] ? POLY : 32'h0)
              ^ fold;

`ifdef FUZZ_SEQ_STALL_EN
  assign hold = bus.stall && (state_q == S_APPLY ||
                              state_q == S_SETTLE ||
                              state_q == S_CAPTURE);
`else
  assign hold = 1'b0;
`endif

  // XOR-fold the zero-extended response into one 32-bit word
  always_comb begin
    fold = '0;
    for (int i = 0; i < NCH; i++) begin
      fold = fold ^ y_ext[i*32 +: 32];
    end
  end

  // Next-state and datapath updates; hold then abort override
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    vec_d   = vec_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    set_d   = set_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          lfsr_d  = (bus.seed == 64'h0) ? 64'h1 : bus.seed;
          sig_d   = '0;
          cnt_d   = '0;
          set_d   = '0;
          busy_d  = 1'b1;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        vec_d   = lfsr_q[VEC_W-1:0];
        lfsr_d  = lfsr_adv;
        state_d = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
      end
      S_SETTLE: begin
        if (set_q == SET_LAST) begin
          set_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        sig_d = misr;
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == NV) begin
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (hold) begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      vec_d   = vec_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      set_d   = set_q;
      busy_d  = busy_q;
    end
    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      lfsr_d  = lfsr_q;
      vec_d   = vec_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      set_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= 64'h1;
      vec_q   <= '0;
      sig_q   <= '0;
      cnt_q   <= '0;
      set_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      vec_q   <= vec_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.vec_out   = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.vec_cnt   = cnt_q;
  assign bus.signature = sig_q;

endmodule

// File: tb/tb_fuzz_vec_sequencer.sv
// tb_fuzz_vec_sequencer: directed checks of fuzz_vec_sequencer
// with NUM_VEC=4, SETTLE=1.
module tb_fuzz_vec_sequencer;
  localparam int VEC_W = 49;
  localparam int Y_W   = 350;
  localparam int CNT_W = 8;
  localparam int NC    = 40;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fuzz_vec_sequencer_if #(
    .VEC_W(VEC_W), .Y_W(Y_W), .CNT_W(CNT_W)
  ) bus ();

  fuzz_vec_sequencer #(
    .VEC_W(VEC_W), .Y_W(Y_W), .NUM_VEC(4),
    .SETTLE(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  int errs = 0;
  int checks = 0;

  logic [VEC_W-1:0] vs [NC];
  logic [CNT_W-1:0] vc [NC];
  logic [31:0]      sg [NC];
  logic             bz [NC];
  int busy_n, done_n, done_at;
`ifdef FUZZ_SEQ_STALL_EN
  int stall_at = -1;
`endif

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // start a run, then observe NC cycles after the start edge
  task automatic run(input logic [63:0] sd,
                     input int ab_at,
                     input int st_at);
    @(negedge clk);
    bus.seed  = sd;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    for (int c = 0; c < NC; c++) begin
      vs[c] = bus.vec_out;
      vc[c] = bus.vec_cnt;
      sg[c] = bus.signature;
      bz[c] = bus.busy;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      bus.start = (c == st_at);
      bus.abort = (c == ab_at);
`ifdef FUZZ_SEQ_STALL_EN
      bus.stall = (stall_at >= 0 && c >= stall_at &&
                   c < stall_at + 5);
`endif
      @(posedge clk);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
`ifdef FUZZ_SEQ_STALL_EN
    bus.stall = 1'b0;
`endif
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.seed  = '0;
    bus.y     = '0;
`ifdef FUZZ_SEQ_STALL_EN
    bus.stall = 1'b0;
`endif
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_vec", 64'(bus.vec_out), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_done", 64'(bus.done), 64'h0);
    chk("rst_cnt", 64'(bus.vec_cnt), 64'h0);
    chk("rst_sig", 64'(bus.signature), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // zero response, seed 1
    bus.y = '0;
    run(64'h1, -1, -1);
    chk("z_done_at", 64'(done_at), 64'd13);
    chk("z_busy_n", 64'(busy_n), 64'd12);
    chk("z_done_n", 64'(done_n), 64'd1);
    chk("z_cnt", 64'(vc[NC-1]), 64'd4);
    chk("z_sig_mid", 64'(sg[6]), 64'h0);
    chk("z_sig_end", 64'(sg[NC-1]), 64'h0);
    chk("z_vec1", 64'(vs[1]), 64'h1);
    chk("z_vec2", 64'(vs[4]), 64'h0);

    // all-ones response, zero seed substituted
    bus.y = '1;
    run(64'h0, -1, -1);
    chk("o_vec1", 64'(vs[1]), 64'h1);
    chk("o_vec2", 64'(vs[4]), 64'h0);
    chk("o_sig1", 64'(sg[3]), 64'h3FFFFFFF);
    chk("o_cnt1", 64'(vc[3]), 64'd1);
    chk("o_sig4", 64'(sg[20]), 64'h44C11DB2);
    chk("o_sig_hold", 64'(sg[NC-1]), 64'h44C11DB2);
    chk("o_done_n", 64'(done_n), 64'd1);

    // distinctive seed: first two vectors
    run(64'h0001_2345_6789_ABCD, -1, -1);
    chk("s_vec1", 64'(vs[1]), 64'h1_2345_6789_ABCD);
    chk("s_vec2", 64'(vs[4]), 64'h0_91A2_B3C4_D5E6);

    // abort during 2nd vector settle
    run(64'h1, 4, -1);
    chk("a_busy", 64'(bz[5]), 64'h0);
    chk("a_cnt", 64'(vc[5]), 64'd1);
    chk("a_done_n", 64'(done_n), 64'd0);
    chk("a_sig", 64'(sg[NC-1]), 64'h3FFFFFFF);
    chk("a_cnt_end", 64'(vc[NC-1]), 64'd1);
    run(64'h1, -1, -1);
    chk("r_cnt0", 64'(vc[0]), 64'd0);
    chk("r_sig0", 64'(sg[0]), 64'h0);
    chk("r_done_at", 64'(done_at), 64'd13);
    chk("r_sig_end", 64'(sg[NC-1]), 64'h44C11DB2);

    // start pulse while busy is ignored
    run(64'h1, -1, 3);
    chk("b_done_at", 64'(done_at), 64'd13);
    chk("b_done_n", 64'(done_n), 64'd1);
    chk("b_busy_n", 64'(busy_n), 64'd12);
    chk("b_cnt", 64'(vc[NC-1]), 64'd4);

`ifdef FUZZ_SEQ_STALL_EN
    // 5 stall cycles in the first settle
    stall_at = 1;
    run(64'h1, -1, -1);
    stall_at = -1;
    chk("st_done_at", 64'(done_at), 64'd18);
    chk("st_busy_n", 64'(busy_n), 64'd17);
    chk("st_sig", 64'(sg[NC-1]), 64'h44C11DB2);
`endif

    // async reset in the 2nd capture state
    @(negedge clk);
    bus.seed  = 64'h0001_2345_6789_ABCD;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("ar_pre_sig", 64'(bus.signature), 64'h3FFFFFFF);
    chk("ar_pre_busy", 64'(bus.busy), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vec", 64'(bus.vec_out), 64'h0);
    chk("ar_sig", 64'(bus.signature), 64'h0);
    chk("ar_cnt", 64'(bus.vec_cnt), 64'h0);
    chk("ar_busy", 64'(bus.busy), 64'h0);
    chk("ar_done", 64'(bus.done), 64'h0);
    done_n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    chk("ar_done_n", 64'(done_n), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
